// File: rtl/address_update_w.sv
// Write-side address generator and pixel packer for the edge-detection AHB master.
// Packs 8-bit result pixels four per 32-bit word and requests one write per word.
//
// Ports:
//   HCLK, HRESET        clock, synchronous active-high reset
//   start               pulse: latch addr/length/width, clear counters
//   status              2'b10 = run, anything else = pause
//   length, width       input image rows / columns
//   addr                output base address (word aligned on latch)
//   pix_valid/pix_data  pixel stream in, pix_ready accepts
//   wr_req/wr_addr/wr_data/wr_done   write handshake to the AHB master
//   curr_addr           address of the next word to write
//   end_of_image        all output words written
//
// Option: define ADDRESS_UPDATE_W_BIG_ENDIAN_EN for big-endian byte lanes.
module address_update_w (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic [1:0]  status,
  input  logic [15:0] length,
  input  logic [15:0] width,
  input  logic [31:0] addr,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_done,
  output logic [31:0] curr_addr,
  output logic        end_of_image
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [31:0] total;
  logic [31:0] total_d;
  logic [31:0] pix_cnt;
  logic [31:0] pix_cnt_d;
  logic [31:0] wbuf;
  logic [31:0] wbuf_d;
  logic [1:0]  byte_idx;
  logic [1:0]  byte_idx_d;
  logic [31:0] curr_addr_d;
  logic [31:0] wr_addr_d;
  logic [31:0] wr_data_d;
  logic        wr_req_d;
  logic        eoi_d;
  logic        accept;
  logic [15:0] len_m2;
  logic [15:0] wid_m2;
  logic [31:0] start_total;
  logic [4:0]  lane;

  assign len_m2 = length - 16'd2;
  assign wid_m2 = width - 16'd2;

  // Border rows/columns are lost to the 3x3 window.
  assign start_total = (length < 16'd3 || width < 16'd3) ? 32'd0
                     : {16'd0, len_m2} * {16'd0, wid_m2};

`ifdef ADDRESS_UPDATE_W_BIG_ENDIAN_EN
  assign lane = 5'd24 - {byte_idx, 3'b000};
`else
  assign lane = {byte_idx, 3'b000};
`endif

  always_comb begin
    state_d     = state;
    total_d     = total;
    pix_cnt_d   = pix_cnt;
    byte_idx_d  = byte_idx;
    wbuf_d      = wbuf;
    curr_addr_d = curr_addr;
    wr_req_d    = wr_req;
    wr_addr_d   = wr_addr;
    wr_data_d   = wr_data;
    eoi_d       = end_of_image;
    pix_ready   = (state == FILL) && (status == 2'b10);
    accept      = pix_ready && pix_valid;

    if (start) begin
      // A restart abandons any pending request; wr_done is ignored.
      total_d     = start_total;
      pix_cnt_d   = 32'd0;
      byte_idx_d  = 2'd0;
      wbuf_d      = 32'd0;
      curr_addr_d = {addr[31:2], 2'b00};
      wr_req_d    = 1'b0;
      eoi_d       = (start_total == 32'd0);
      state_d     = (start_total == 32'd0) ? DONE : FILL;
    end else begin
      unique case (state)
        FILL: begin
          if (accept) begin
            wbuf_d[lane +: 8] = pix_data;
            pix_cnt_d         = pix_cnt + 32'd1;
            byte_idx_d        = byte_idx + 2'd1;
            if (byte_idx == 2'd3 || pix_cnt_d == total) begin
              state_d   = WRITE;
              wr_req_d  = 1'b1;
              wr_addr_d = curr_addr;
              wr_data_d = wbuf_d;
            end
          end
        end
        WRITE: begin
          if (wr_done) begin
            wr_req_d    = 1'b0;
            curr_addr_d = curr_addr + 32'd4;
            wbuf_d      = 32'd0;
            byte_idx_d  = 2'd0;
            if (pix_cnt == total) begin
              state_d = DONE;
              eoi_d   = 1'b1;
            end else begin
              state_d = FILL;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state        <= IDLE;
      total        <= 32'd0;
      pix_cnt      <= 32'd0;
      byte_idx     <= 2'd0;
      wbuf         <= 32'd0;
      curr_addr    <= 32'd0;
      wr_req       <= 1'b0;
      wr_addr      <= 32'd0;
      wr_data      <= 32'd0;
      end_of_image <= 1'b0;
    end else begin
      state        <= state_d;
      total        <= total_d;
      pix_cnt      <= pix_cnt_d;
      byte_idx     <= byte_idx_d;
      wbuf         <= wbuf_d;
      curr_addr    <= curr_addr_d;
      wr_req       <= wr_req_d;
      wr_addr      <= wr_addr_d;
      wr_data      <= wr_data_d;
      end_of_image <= eoi_d;
    end
  end

endmodule

// File: doc/address_update_w.md
# address_update_w

Write-side address generator and pixel packer for the AHB master of the edge-detection engine. It accepts 8-bit result pixels from the Sobel datapath and packs them four per 32-bit word. For each word it issues a write request to the AHB master at an auto-incrementing word address, starting from the output image base address. It mirrors `address_update_r`, which generates the read addresses, and flags `end_of_image` once the last output word has been written.

## Interface
- No parameters.
- `HCLK` in 1: system clock; all logic rising-edge.
- `HRESET` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse; latches `addr`, `length`, `width`; clears counters.
- `status` in 2: `2'b10` = run; any other value = pause.
- `length` in 16: input image rows.
- `width` in 16: input image columns.
- `addr` in 32: output base address; bits [1:0] forced to 0 on latch.
- `pix_valid` in 1: `pix_data` is valid.
- `pix_data` in 8: result pixel, raster order.
- `pix_ready` out 1: block accepts a pixel this cycle.
- `wr_req` out 1: write request to the AHB master.
- `wr_addr` out 32: write address; held while `wr_req` is high.
- `wr_data` out 32: packed word; held while `wr_req` is high.
- `wr_done` in 1: AHB master completed the requested write.
- `curr_addr` out 32: address of the next word to write.
- `end_of_image` out 1: all output words written.

## Operation
- States: `IDLE`, `FILL`, `WRITE`, `DONE`.
- Total pixels `T` = (length−2)×(width−2), 32-bit unsigned, computed at `start`.
  - `T` = 0 if `length` < 3 or `width` < 3.
- `start` (accepted in any state):
  - `curr_addr` ← `{addr[31:2],2'b00}`.
  - Pixel counter ← 0; byte index ← 0; word buffer ← 0.
  - Next state: `FILL`, or `DONE` if `T` = 0.
- `FILL`:
  - `pix_ready` = (`status` == `2'b10`).
  - An accepted pixel (`pix_valid & pix_ready`) is written into byte lane `byte_idx`; `byte_idx` and the pixel counter increment.
  - On acceptance of the 4th byte, or of pixel number `T`: go to `WRITE`.
- `WRITE`:
  - `wr_req` = 1, `wr_addr` = `curr_addr`, `wr_data` = buffer. Unfilled lanes of a partial final word are 0.
  - `pix_ready` = 0.
  - Pause via `status` does not drop an issued request.
  - On `wr_done`: `curr_addr` += 4 (wraps mod 2^32), buffer and `byte_idx` clear. Go to `DONE` if the counter equals `T`, else `FILL`.
- `DONE`: `end_of_image` = 1 until the next `start` or `HRESET`. `pix_ready` = 0.
- `wr_done` outside `WRITE` is ignored.
- `pix_valid` while `pix_ready` = 0 is ignored; no pixel is consumed.
- `start` during `WRITE` abandons the pending request: `wr_req` falls the next cycle. The AHB master must tolerate the abandoned request.
- `start` and `wr_done` in the same cycle: `start` wins; `curr_addr` is not incremented.
- `IDLE` (after reset only): all handshake outputs are low.

## Timing
- Reset values: `pix_ready` 0, `wr_req` 0, `wr_addr` 0, `wr_data` 0, `curr_addr` 0, `end_of_image` 0, state `IDLE`.
- All outputs are registered except `pix_ready`, which is combinational from state and `status`.
- A word-completing pixel accepted at edge N drives `wr_req` high in the cycle after edge N.
- `wr_done` sampled at edge M: `wr_req` is low and `curr_addr` is updated after edge M. `pix_ready` may be high in the cycle after edge M.
- Peak throughput: 4 pixels + 1 write cycle = 5 cycles per word, with `wr_done` returned immediately.
- `end_of_image` rises in the cycle after the `wr_done` of the final word. For `T` = 0 it rises in the cycle after `start`.

## Configuration
- `ADDRESS_UPDATE_W_BIG_ENDIAN_EN`
  - Undefined (default): little-endian lanes; pixel k of a word occupies `wr_data[8k+7:8k]`.
  - Defined: big-endian lanes; pixel k occupies `wr_data[31−8k:24−8k]`.
  - Zero padding of a partial final word applies in both modes.

## Test plan
- Full image: `length`=10, `width`=7, `addr`=0x1000, pixels always valid, `wr_done` one cycle after `wr_req` → 40 pixels, 10 writes at addresses 0x1000 … 0x1024; final `curr_addr` = 0x1028; `end_of_image` = 1.
- Partial word: `length`=5, `width`=4, pixels 0x01 … 0x06 → `wr_data` 0x04030201 then 0x00000605. With the macro defined: 0x01020304 then 0x05060000.
- Pause: `status` = `2'b00` for 5 cycles after 2 pixels → `pix_ready` = 0 throughout and no pixel consumed. After resume the word completes as 0x04030201. A pause asserted while `wr_req` is high leaves `wr_req` high until `wr_done`.
- Degenerate dimensions: `length`=2, `width`=7, `start` → `end_of_image` = 1 in the next cycle; `wr_req` never asserts.
- Back-pressure: `wr_done` delayed 6 cycles → `wr_req`, `wr_addr` and `wr_data` stable all 6 cycles; `pix_ready` = 0 throughout.
- Mid-operation reset/restart: `HRESET` asserted while `wr_req` = 1 → all outputs return to reset values the next cycle. A separate run with `start` issued during `WRITE` → `wr_req` falls, `curr_addr` reloads to `addr`, counting restarts from 0.
